nbit_sh_rx: RTL and testbench
=============================

# nbit_sh_rx

Serial frame receiver that deserializes the single-bit stream produced by the `nbit_sh_reg` transmit path back into `nbit`-wide parallel words. It sits on the receive side of the link, with one serial bit presented per `bit_en` strobe. It recognises a start bit, shifts in `nbit` data bits, optionally checks parity, and validates the stop bit. The assembled word is held for a downstream consumer behind a valid/ack handshake.

## Interface
- `nbit`, 4: data bits per frame; legal range 2 to 32.
- `msb_first`, 1: 1 = first data bit received lands in `data_out[nbit-1]` (matches left-shift transmit); 0 = first bit lands in `data_out[0]`.
- `parity_en`, 0: 1 = one parity bit follows the data bits; 0 = no parity bit.
- `parity_odd`, 0: 0 = even parity, 1 = odd parity; ignored when `parity_en`=0.
- `clk_main` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `bit_en` input 1: bit strobe, one-cycle pulse per serial bit period; `sin` is sampled only on cycles with `bit_en`=1.
- `sin` input 1: serial data, synchronous to `clk_main`; line idles at 1.
- `rd_ack` input 1: consumer accepts the held word.
- `data_out` output nbit: last successfully received word.
- `data_valid` output 1: held high from word delivery until accepted.
- `busy` output 1: high while a frame is in progress (any state other than IDLE).
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0.
- `parity_err` output 1: one-cycle pulse on a parity mismatch.
- `overrun` output 1: one-cycle pulse when a good frame completes while `data_valid` is still 1.

## Operation
- States:
  - **IDLE** waits for a start bit.
  - **DATA** shifts in data bits.
  - **PAR** samples the parity bit.
  - **STOP** samples the stop bit.
- **IDLE:**
  - `bit_en` & `sin`=0 → DATA, bit counter = 0, shift register cleared.
  - `bit_en` & `sin`=1 → stay in IDLE.
- **DATA:** on each `bit_en`:
  - Shift `sin` in. For `msb_first`=1, shift left with `sin` into bit 0; otherwise shift right with `sin` into bit `nbit-1`.
  - Increment the counter.
  - After the `nbit`th bit → PAR if `parity_en`, else → STOP.
  - The counter is `$clog2(nbit+1)` bits wide and never wraps within a frame.
- **PAR:** on `bit_en`:
  - Compute the expected bit as XOR of the shifted data XOR `parity_odd`.
  - On a mismatch, mark the frame bad and pulse `parity_err`.
  - → STOP.
- **STOP:** on `bit_en` → IDLE, then:
  - `sin`=1 and frame not bad: deliver the word.
  - `sin`=0: pulse `frame_err`; the word is discarded.
- **Delivery:**
  - If `data_valid`=0: load `data_out` and set `data_valid`.
  - If `data_valid`=1: `data_out` is unchanged, the new word is dropped, and `overrun` pulses.
- **Bad frames** (parity or framing) never update `data_out` or `data_valid`.
- **Handshake:**
  - `rd_ack` while `data_valid`=1 clears `data_valid` next cycle.
  - `rd_ack` while `data_valid`=0 is ignored.
  - `rd_ack` in the same cycle as a delivery:
    - Clear-then-load: the new word is accepted, `data_valid` stays 1, and no `overrun` occurs.
- **Back-to-back frames:** a start bit may appear on the `bit_en` immediately after the stop bit.
- **Reset** (asserted at any time, including mid-frame):
  - State → IDLE, counter and shift register → 0.
  - `data_out`=0, `data_valid`=0, `busy`=0; all error pulses 0.
  - A partial frame is lost.

## Timing
- All outputs are registered.
- `busy` rises the cycle after the start-bit `bit_en` and falls the cycle after the stop-bit `bit_en`.
- `data_out`, `data_valid`, `frame_err` and `overrun` update one cycle after the stop-bit `bit_en`.
- `parity_err` pulses one cycle after the parity-bit `bit_en`.
- Frame length is 1 + `nbit` + `parity_en` + 1 strobes.
- Cycles with `bit_en`=0 hold all state; `bit_en` spacing may vary, down to every cycle.
- `rd_ack` takes effect on the next edge; `data_valid` can be reasserted no sooner than the next delivery.

## Test plan
- Reset and idle:
  - Assert `reset`=0 mid-frame → all outputs 0, `busy`=0 immediately (asynchronous).
  - Release reset, hold `sin`=1 for 10 strobes → no activity.
- Basic receive, `nbit`=4, `msb_first`=1, no parity:
  - Send start 0, data 1,0,1,1, stop 1 → `data_out`=4'b1011, `data_valid`=1 one cycle after the stop strobe.
  - `rd_ack` → `data_valid`=0.
- LSB-first:
  - `msb_first`=0, same bits 1,0,1,1 → `data_out`=4'b1101.
- Parity, even:
  - Data 1,0,1,1 with parity bit 1 → delivered.
  - Same data with parity bit 0 → `parity_err` pulse, `data_valid` stays 0.
- Framing error:
  - Stop bit 0 → `frame_err` pulse, `data_out` unchanged.
  - Immediately follow with a good frame 0110 → delivered.
- Overrun and handshake:
  - Two good frames 0011 then 1100 with no `rd_ack` → `data_out`=0011, `overrun` pulses once.
  - Repeat with `rd_ack` coincident with the second delivery → `data_out`=1100, `data_valid`=1, no `overrun`.

Source files
------------

// File: rtl/nbit_sh_rx.sv
// Serial frame receiver: start bit, nbit data bits, optional parity, stop bit.
// The assembled word is held for a downstream consumer behind a valid/ack handshake.
module nbit_sh_rx #(
    parameter int nbit       = 4,
    parameter int msb_first  = 1,
    parameter int parity_en  = 0,
    parameter int parity_odd = 0
) (
    input  logic            clk_main,
    input  logic            reset,
    input  logic            bit_en,
    input  logic            sin,
    input  logic            rd_ack,
    output logic [nbit-1:0] data_out,
    output logic            data_valid,
    output logic            busy,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun
);

    localparam int CW = $clog2(nbit + 1);
    localparam logic ODD = (parity_odd != 0);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [nbit-1:0] shreg;
    logic            bad;

    function automatic logic [nbit-1:0] shift_in(input logic [nbit-1:0] cur, input logic b);
        if (msb_first != 0)
            return {cur[nbit-2:0], b};
        else
            return {b, cur[nbit-1:1]};
    endfunction

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            bad        <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            // A delivery later in this block overrides the clear (clear-then-load).
            if (rd_ack && data_valid)
                data_valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!sin) begin
                            state <= DATA;
                            cnt   <= '0;
                            shreg <= '0;
                            bad   <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg <= shift_in(shreg, sin);
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(nbit - 1))
                            state <= (parity_en != 0) ? PAR : STOP;
                    end
                    PAR: begin
                        if (sin != ((^shreg) ^ ODD)) begin
                            bad        <= 1'b1;
                            parity_err <= 1'b1;
                        end
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!sin) begin
                            frame_err <= 1'b1;
                        end else if (!bad) begin
                            if (data_valid && !rd_ack) begin
                                overrun <= 1'b1;
                            end else begin
                                data_out   <= shreg;
                                data_valid <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nbit_sh_rx.sv
// Bench for nbit_sh_rx: instance 0 is MSB-first without parity, instance 1 is
// LSB-first with even parity; outputs are compared against a frame-level model.
module tb_nbit_sh_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en_v [2];
    logic       sin_v    [2];
    logic       ack_v    [2];
    logic [3:0] dout     [2];
    logic       valid    [2];
    logic       busy     [2];
    logic       ferr     [2];
    logic       perr     [2];
    logic       ovr      [2];

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_data  [2];
    logic       exp_valid [2];

    always #5 clk = ~clk;

    nbit_sh_rx #(.nbit(4), .msb_first(1), .parity_en(0), .parity_odd(0)) u_msb (
        .clk_main(clk), .reset(rst_n), .bit_en(bit_en_v[0]), .sin(sin_v[0]),
        .rd_ack(ack_v[0]), .data_out(dout[0]), .data_valid(valid[0]), .busy(busy[0]),
        .frame_err(ferr[0]), .parity_err(perr[0]), .overrun(ovr[0]));

    nbit_sh_rx #(.nbit(4), .msb_first(0), .parity_en(1), .parity_odd(0)) u_lsb (
        .clk_main(clk), .reset(rst_n), .bit_en(bit_en_v[1]), .sin(sin_v[1]),
        .rd_ack(ack_v[1]), .data_out(dout[1]), .data_valid(valid[1]), .busy(busy[1]),
        .frame_err(ferr[1]), .parity_err(perr[1]), .overrun(ovr[1]));

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input int k, input string tag, input logic fe, input logic ov);
        chk_eq({tag, ".data"}, 32'(dout[k]), 32'(exp_data[k]));
        chk_eq({tag, ".valid"}, 32'(valid[k]), 32'(exp_valid[k]));
        chk_eq({tag, ".busy"}, 32'(busy[k]), 0);
        chk_eq({tag, ".frame_err"}, 32'(ferr[k]), 32'(fe));
        chk_eq({tag, ".overrun"}, 32'(ovr[k]), 32'(ov));
    endtask

    // Called at a negedge; returns at the next negedge with the strobe consumed.
    task automatic strobe(input int k, input logic b);
        bit_en_v[k] = 1'b1;
        sin_v[k]    = b;
        @(negedge clk);
        bit_en_v[k] = 1'b0;
        sin_v[k]    = 1'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // seq[3] is the first data bit on the line.
    task automatic send_frame(input int k, input logic [3:0] seq, input logic par,
                              input logic stp, input logic ack, input string tag);
        logic [3:0] word;
        logic       bad_par;
        logic       fe, ov;
        word = (k == 0) ? seq : {seq[0], seq[1], seq[2], seq[3]};
        strobe(k, 1'b0);
        chk_eq({tag, ".busy_start"}, 32'(busy[k]), 1);
        gap();
        for (int i = 3; i >= 0; i--) begin
            strobe(k, seq[i]);
            gap();
        end
        bad_par = 1'b0;
        if (k == 1) begin
            bad_par = (par != (^word));
            strobe(k, par);
            chk_eq({tag, ".parity_err"}, 32'(perr[k]), 32'(bad_par));
            gap();
        end
        ack_v[k] = ack;
        strobe(k, stp);
        ack_v[k] = 1'b0;
        fe = !stp;
        ov = 1'b0;
        if (ack && exp_valid[k])
            exp_valid[k] = 1'b0;
        if (stp && !bad_par) begin
            if (exp_valid[k]) begin
                ov = 1'b1;
            end else begin
                exp_data[k]  = word;
                exp_valid[k] = 1'b1;
            end
        end
        check_all(k, tag, fe, ov);
    endtask

    task automatic ack_pulse(input int k, input string tag);
        ack_v[k] = 1'b1;
        @(negedge clk);
        ack_v[k] = 1'b0;
        exp_valid[k] = 1'b0;
        chk_eq({tag, ".valid_after_ack"}, 32'(valid[k]), 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            bit_en_v[k] = 1'b0;
            sin_v[k]    = 1'b1;
            ack_v[k]    = 1'b0;
            exp_data[k] = '0;
            exp_valid[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) check_all(k, "reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        send_frame(0, 4'b1011, 1'b0, 1'b1, 1'b0, "msb_basic");
        ack_pulse(0, "msb_basic");
        send_frame(0, 4'b0101, 1'b0, 1'b1, 1'b0, "msb_second");

        // Asynchronous reset in the middle of a frame while a word is held.
        strobe(0, 1'b0);
        strobe(0, 1'b1);
        strobe(0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        exp_data[0] = '0; exp_valid[0] = 1'b0;
        exp_data[1] = '0; exp_valid[1] = 1'b0;
        check_all(0, "async_reset", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (10) begin
            strobe(0, 1'b1);
            chk_eq("idle.busy", 32'(busy[0]), 0);
        end
        check_all(0, "idle", 1'b0, 1'b0);

        send_frame(1, 4'b1011, 1'b1, 1'b1, 1'b0, "lsb_par_good");
        chk_eq("lsb_word", 32'(dout[1]), 32'h0000_000d);
        ack_pulse(1, "lsb_par_good");
        send_frame(1, 4'b1011, 1'b0, 1'b1, 1'b0, "lsb_par_bad");

        send_frame(0, 4'b1010, 1'b0, 1'b0, 1'b0, "frame_err");
        send_frame(0, 4'b0110, 1'b0, 1'b1, 1'b0, "after_ferr");
        ack_pulse(0, "after_ferr");

        send_frame(0, 4'b0011, 1'b0, 1'b1, 1'b0, "ovr_first");
        send_frame(0, 4'b1100, 1'b0, 1'b1, 1'b0, "ovr_second");
        ack_pulse(0, "ovr");
        send_frame(0, 4'b0011, 1'b0, 1'b1, 1'b0, "coinc_first");
        send_frame(0, 4'b1100, 1'b0, 1'b1, 1'b1, "coinc_second");

        for (int n = 0; n < 60; n++) begin
            int         k;
            logic [3:0] seq;
            logic       par;
            k   = int'($urandom_range(0, 1));
            seq = 4'($urandom);
            par = (^seq) ^ ($urandom_range(0, 3) == 0);
            send_frame(k, seq, par, ($urandom_range(0, 7) != 0),
                       ($urandom_range(0, 3) == 0), "rand");
            if ($urandom_range(0, 2) == 0)
                ack_pulse(k, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
